// File: rtl/ex_flag_stage.sv
// ex_flag_stage: single-entry register stage between ALU and writeback that
// resolves conditional execution against committed carry/zero flags, updates
// those flags, and counts beats squashed by their condition.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   ALU-side handshake (in_ready is combinational)
//   op, cond            operation class and execute condition of the beat
//   alu_result/carry/zero, rd   ALU beat payload
//   flush               discard the held beat, accept nothing this cycle
//   out_valid/out_ready writeback-side handshake
//   out_result, out_rd, out_wr_en   held beat
//   c_flag, z_flag      committed flags
//   skip_cnt            saturating count of condition-squashed beats
module ex_flag_stage #(
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    op,
   input  logic [1:0]    cond,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_carry,
   input  logic          alu_zero,
   input  logic [RW-1:0] rd,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_result,
   output logic [RW-1:0] out_rd,
   output logic          out_wr_en,
   output logic          c_flag,
   output logic          z_flag,
   output logic [7:0]    skip_cnt
);

   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_result_q, out_result_d;
   logic [RW-1:0] out_rd_q, out_rd_d;
   logic          out_wr_en_q, out_wr_en_d;
   logic          c_flag_q, c_flag_d;
   logic          z_flag_q, z_flag_d;
   logic [7:0]    skip_cnt_q, skip_cnt_d;

   logic accept;
   logic exec;

   // Reset also blocks acceptance so nothing is taken in the reset cycle.
   assign in_ready = (!out_valid_q || out_ready) && !flush && !rst;
   assign accept   = in_valid && in_ready;

   // Condition is judged on the flags as committed right now; a beat accepted
   // on the previous edge has already written them, so there is no bubble.
   always_comb begin
      exec = 1'b1;
      case (cond)
         2'b10:   exec = c_flag_q;
         2'b01:   exec = z_flag_q;
         default: exec = 1'b1;
      endcase
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_rd_d     = out_rd_q;
      out_wr_en_d  = out_wr_en_q;
      c_flag_d     = c_flag_q;
      z_flag_d     = z_flag_q;
      skip_cnt_d   = skip_cnt_q;

      if (flush) begin
         out_valid_d = 1'b0;
         out_wr_en_d = 1'b0;
      end else if (accept) begin
         out_valid_d  = 1'b1;
         out_result_d = alu_result;
         out_rd_d     = rd;
         out_wr_en_d  = exec;
         if (exec) begin
            case (op)
               2'b00: begin
                  c_flag_d = alu_carry;
                  z_flag_d = alu_zero;
               end
               2'b01:   z_flag_d = alu_zero;
               default: ;
            endcase
         end else if (skip_cnt_q != 8'hFF) begin
            skip_cnt_d = skip_cnt_q + 8'd1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_wr_en_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_rd_q     <= '0;
         out_wr_en_q  <= 1'b0;
         c_flag_q     <= 1'b0;
         z_flag_q     <= 1'b0;
         skip_cnt_q   <= 8'd0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_rd_q     <= out_rd_d;
         out_wr_en_q  <= out_wr_en_d;
         c_flag_q     <= c_flag_d;
         z_flag_q     <= z_flag_d;
         skip_cnt_q   <= skip_cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_rd     = out_rd_q;
   assign out_wr_en  = out_wr_en_q;
   assign c_flag     = c_flag_q;
   assign z_flag     = z_flag_q;
   assign skip_cnt   = skip_cnt_q;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Testbench for ex_flag_stage: table of per-cycle vectors with hand-computed
// flag/skip/write-enable expectations, and a queue scoreboard for emitted beats.
module tb_ex_flag_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [1:0]  cond;
   logic [15:0] alu_result;
   logic        alu_carry;
   logic        alu_zero;
   logic [2:0]  rd;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [2:0]  out_rd;
   logic        out_wr_en;
   logic        c_flag;
   logic        z_flag;
   logic [7:0]  skip_cnt;

   always #5 clk = ~clk;

   ex_flag_stage #(.DW(16), .RW(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .cond(cond), .alu_result(alu_result), .alu_carry(alu_carry),
      .alu_zero(alu_zero), .rd(rd), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
      .out_wr_en(out_wr_en), .c_flag(c_flag), .z_flag(z_flag), .skip_cnt(skip_cnt)
   );

   typedef struct {
      logic        in_valid;
      logic [1:0]  op;
      logic [1:0]  cond;
      logic [15:0] res;
      logic        carry;
      logic        zero;
      logic [2:0]  rd;
      logic        out_ready;
      logic        flush;
      logic        exp_wr;
      logic        exp_c;
      logic        exp_z;
      logic [7:0]  exp_skip;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic [2:0]  rd;
      logic        wr;
   } beat_t;

   beat_t sb_q[$];
   logic  m_valid;
   int    errors = 0;
   int    checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic iv, input logic [1:0] o, input logic [1:0] c,
                               input logic [15:0] r, input logic ca, input logic ze,
                               input logic [2:0] d, input logic ordy, input logic fl,
                               input logic ew, input logic ec, input logic ez,
                               input logic [7:0] es);
      vec_t v;
      v.in_valid = iv; v.op = o; v.cond = c; v.res = r; v.carry = ca; v.zero = ze;
      v.rd = d; v.out_ready = ordy; v.flush = fl; v.exp_wr = ew; v.exp_c = ec;
      v.exp_z = ez; v.exp_skip = es;
      return v;
   endfunction

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic apply(input vec_t v);
      logic        exp_ready, acc, hold;
      logic [15:0] s_res;
      logic [2:0]  s_rd;
      logic        s_wr;
      beat_t       b;
      in_valid   = v.in_valid;
      op         = v.op;
      cond       = v.cond;
      alu_result = v.res;
      alu_carry  = v.carry;
      alu_zero   = v.zero;
      rd         = v.rd;
      out_ready  = v.out_ready;
      flush      = v.flush;
      #1;
      exp_ready = (!m_valid || v.out_ready) && !v.flush;
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      acc  = v.in_valid && exp_ready;
      hold = m_valid && !v.out_ready && !v.flush;
      s_res = out_result; s_rd = out_rd; s_wr = out_wr_en;
      if (m_valid && v.flush) begin
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else if (m_valid && v.out_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
         end else begin
            b = sb_q.pop_front();
            chk("sb_result", 32'(out_result), 32'(b.res));
            chk("sb_rd", 32'(out_rd), 32'(b.rd));
            chk("sb_wr_en", 32'(out_wr_en), 32'(b.wr));
         end
      end
      if (acc) begin
         b.res = v.res; b.rd = v.rd; b.wr = v.exp_wr;
         sb_q.push_back(b);
      end
      if (v.flush)            m_valid = 1'b0;
      else if (acc)           m_valid = 1'b1;
      else if (v.out_ready)   m_valid = 1'b0;
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (!m_valid) chk("wr_en_idle", 32'(out_wr_en), 32'd0);
      if (acc) begin
         chk("acc_result", 32'(out_result), 32'(v.res));
         chk("acc_wr_en", 32'(out_wr_en), 32'(v.exp_wr));
      end
      if (hold) begin
         chk("hold_result", 32'(out_result), 32'(s_res));
         chk("hold_rd", 32'(out_rd), 32'(s_rd));
         chk("hold_wr_en", 32'(out_wr_en), 32'(s_wr));
      end
      chk("c_flag", 32'(c_flag), 32'(v.exp_c));
      chk("z_flag", 32'(z_flag), 32'(v.exp_z));
      chk("skip_cnt", 32'(skip_cnt), 32'(v.exp_skip));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("in_ready_rst", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_wr_en", 32'(out_wr_en), 32'd0);
      chk("rst_result", 32'(out_result), 32'd0);
      chk("rst_rd", 32'(out_rd), 32'd0);
      chk("rst_c", 32'(c_flag), 32'd0);
      chk("rst_z", 32'(z_flag), 32'd0);
      chk("rst_skip", 32'(skip_cnt), 32'd0);
      rst = 1'b0;
      sb_q.delete();
      m_valid = 1'b0;
   endtask

   vec_t tbl[10];
   vec_t seq[8];

   initial begin
      //          iv op     cond   res      ca  ze  rd    ordy fl   wr   c    z    skip
      tbl[0] = mk(1, 2'b00, 2'b00, 16'h0000, 1, 1, 3'd1, 1, 0, 1, 1, 1, 8'd0);
      tbl[1] = mk(1, 2'b00, 2'b10, 16'h0005, 0, 0, 3'd2, 1, 0, 1, 0, 0, 8'd0);
      tbl[2] = mk(1, 2'b00, 2'b10, 16'h0007, 1, 1, 3'd3, 1, 0, 0, 0, 0, 8'd1);
      tbl[3] = mk(1, 2'b01, 2'b00, 16'h0000, 1, 1, 3'd4, 1, 0, 1, 0, 1, 8'd1);
      tbl[4] = mk(1, 2'b00, 2'b01, 16'h0009, 1, 0, 3'd5, 1, 0, 1, 1, 0, 8'd1);
      tbl[5] = mk(1, 2'b10, 2'b11, 16'h0003, 0, 1, 3'd6, 1, 0, 1, 1, 0, 8'd1);
      tbl[6] = mk(1, 2'b00, 2'b01, 16'h0004, 0, 1, 3'd7, 1, 0, 0, 1, 0, 8'd2);
      tbl[7] = mk(0, 2'b00, 2'b00, 16'h0000, 0, 0, 3'd0, 1, 0, 0, 1, 0, 8'd2);
      tbl[8] = mk(1, 2'b01, 2'b10, 16'hAAAA, 0, 0, 3'd0, 1, 0, 1, 1, 0, 8'd2);
      tbl[9] = mk(1, 2'b11, 2'b00, 16'h0001, 0, 1, 3'd1, 1, 0, 1, 1, 0, 8'd2);
      // stall three cycles, then consume + accept on one edge
      seq[0] = mk(1, 2'b00, 2'b00, 16'h1234, 0, 1, 3'd2, 0, 0, 1, 1, 0, 8'd2);
      seq[1] = seq[0];
      seq[2] = seq[0];
      seq[3] = mk(1, 2'b00, 2'b00, 16'h1234, 0, 1, 3'd2, 1, 0, 1, 0, 1, 8'd2);
      // flush with a held beat and a presented beat; presented beat must not touch flags
      seq[4] = mk(1, 2'b00, 2'b00, 16'h5555, 1, 0, 3'd5, 1, 1, 1, 0, 1, 8'd2);
      seq[5] = mk(1, 2'b01, 2'b01, 16'h0F0F, 1, 0, 3'd3, 1, 0, 1, 0, 0, 8'd2);
      // hold a beat so reset arrives mid-stall
      seq[6] = mk(1, 2'b10, 2'b00, 16'h00FF, 0, 0, 3'd4, 0, 0, 1, 0, 0, 8'd2);
      seq[7] = seq[6];

      rst = 1'b1; in_valid = 0; op = 0; cond = 0; alu_result = 0; alu_carry = 0;
      alu_zero = 0; rd = 0; flush = 0; out_ready = 1; m_valid = 0;
      @(negedge clk);
      do_reset();

      for (int i = 0; i < 10; i++) apply(tbl[i]);
      for (int i = 0; i < 8; i++) apply(seq[i]);

      // reset while a beat is held and a new one is presented
      in_valid = 1'b1;
      out_ready = 1'b0;
      do_reset();
      out_ready = 1'b1;

      // long run of squashed beats: counter saturates at 255
      for (int i = 0; i < 258; i++) begin
         apply(mk(1, 2'b00, 2'b10, 16'(i), 1, 1, 3'(i), 1, 0, 0, 0, 0,
                  (i < 255) ? 8'(i + 1) : 8'd255));
      end
      apply(mk(0, 2'b00, 2'b00, 16'h0000, 0, 0, 3'd0, 1, 0, 0, 0, 0, 8'd255));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_flag_stage.md
EX_FLAG_STAGE -- requirements
Module: ex_flag_stage

Interface
REQ-001 SHALL have parameter DW, default 16: datapath width.
REQ-002 SHALL have parameter RW, default 3: destination register index width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  ALU-stage beat present.
REQ-006 in_ready  out  1  stage can accept a beat this cycle.
REQ-007 op  in  2  00 ADD, 01 NAND, 10/11 PASS (no flag effect).
REQ-008 cond  in  2  00 always, 10 execute if C=1, 01 execute if Z=1, 11 always.
REQ-009 alu_result  in  DW  result from ALU.
REQ-010 alu_carry, alu_zero  in  1 each  ALU carry and zero outputs.
REQ-011 rd  in  RW  destination register.
REQ-012 flush  in  1  discard held beat; block acceptance this cycle.
REQ-013 out_valid  out  1  registered beat available.
REQ-014 out_ready  in  1  writeback consumes beat.
REQ-015 out_result  out  DW; out_rd  out  RW; out_wr_en  out  1 (register write enable of held beat).
REQ-016 c_flag, z_flag  out  1 each  committed flag registers.
REQ-017 skip_cnt  out  8  count of accepted beats squashed by cond, saturating at 255.

Function
REQ-018 in_ready SHALL equal (!out_valid | out_ready) & !flush, combinationally.
REQ-019 Beat SHALL be accepted on an edge where in_valid & in_ready; latency input to out_valid is exactly 1 cycle.
REQ-020 Execute decision exec SHALL be evaluated from c_flag/z_flag values present in the accepting cycle: cond 10 -> c_flag, 01 -> z_flag, else 1.
REQ-021 On accept: out_result<=alu_result, out_rd<=rd, out_wr_en<=exec, out_valid<=1.
REQ-022 On accept with exec=1: op 00 SHALL load c_flag<=alu_carry and z_flag<=alu_zero; op 01 SHALL load z_flag<=alu_zero, c_flag unchanged; op 1x SHALL leave both flags unchanged.
REQ-023 On accept with exec=0: flags unchanged, out_wr_en=0, beat still emitted (in-order retirement), skip_cnt incremented unless at 255.
REQ-024 Back-to-back accepts SHALL see flags written by the immediately preceding accepted beat (flag update and next decision on consecutive edges, no bubble).
REQ-025 When out_valid & !out_ready & !flush: all outputs and flags SHALL hold; in_ready=0.
REQ-026 When out_valid & out_ready & no accept: out_valid<=0 next edge.
REQ-027 Consume and accept on the same edge SHALL replace the held beat with no bubble.
REQ-028 flush=1 SHALL clear out_valid next edge, accept nothing, leave flags and skip_cnt unchanged; flush overrides in_valid and out_ready.
REQ-029 Data outputs with out_valid=0 are don't-care; out_wr_en SHALL be 0 whenever out_valid=0.

Reset
REQ-030 rst=1 SHALL on the next edge set out_valid=0, out_wr_en=0, out_result=0, out_rd=0, c_flag=0, z_flag=0, skip_cnt=0; rst overrides flush and any accept.
REQ-031 in_ready SHALL be 0 while rst=1; a beat held mid-stall at reset SHALL be discarded.

Verification
REQ-032 ADD 0xFFFF+0x0001 (alu_result=0, carry=1, zero=1), cond 00 -> next cycle out_valid=1, out_wr_en=1, c_flag=1, z_flag=1.
REQ-033 With c_flag=0, cond 10 beat -> out_valid=1, out_wr_en=0, flags unchanged, skip_cnt +1.
REQ-034 ADD setting C=1 followed next cycle by cond 10 ADD -> second beat out_wr_en=1 (no bubble).
REQ-035 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs/flags stable; out_ready=1 -> one beat consumed and next accepted same edge.
REQ-036 flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, flags and skip_cnt unchanged; rst mid-stall -> all outputs and flags 0.
REQ-037 256 consecutive squashed beats -> skip_cnt stays at 255.
